// File: rtl/regwb_arbiter.sv
// rtl/regwb_arbiter.sv - two-requester register write-back arbiter; REGWB_RR_EN selects round-robin tie-break
module regwb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_rd,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_rd,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              hold,
  output logic              wrReg,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] rdIn,
  output logic [15:0]       wr_count
);

  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              a_wins_tie;
  logic              can_accept;

`ifdef REGWB_RR_EN
  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_t;
  last_t last_q, last_d;

  // Tie goes to whichever requester was not granted most recently
  always_comb begin
    a_wins_tie = (last_q == LAST_B);
  end

  // Pointer moves only when a handshake actually happens
  always_comb begin
    last_d = last_q;
    if (a_ready) last_d = LAST_A;
    else if (b_ready) last_d = LAST_B;
  end

  // Pointer register; reset lets A win the first tie
  always_ff @(posedge clk) begin
    if (rst) last_q <= LAST_B;
    else     last_q <= last_d;
  end
`else
  // Fixed priority: A always wins a tie
  always_comb begin
    a_wins_tie = 1'b1;
  end
`endif

  // Combinational grants; reset and hold block every acceptance
  always_comb begin
    can_accept = !rst && !hold;
    a_ready    = can_accept && a_valid && (!b_valid || a_wins_tie);
    b_ready    = can_accept && b_valid && (!a_valid || !a_wins_tie);
  end

  // Next write-port state: rd==0 handshakes complete without a write
  always_comb begin
    wr_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (a_ready && (a_rd != '0)) begin
      wr_d   = 1'b1;
      rd_d   = a_rd;
      data_d = a_data;
    end else if (b_ready && (b_rd != '0)) begin
      wr_d   = 1'b1;
      rd_d   = b_rd;
      data_d = b_data;
    end
    cnt_d = cnt_q;
    if (wr_d && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // Write-port and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wrReg    = wr_q;
  assign rd       = rd_q;
  assign rdIn     = data_q;
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_regwb_arbiter.sv
// tb/tb_regwb_arbiter.sv - self-checking bench for regwb_arbiter
module tb_regwb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, hold;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, wrReg;
  logic [4:0]  rd;
  logic [31:0] rdIn;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regwb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .hold(hold),
    .wrReg(wrReg), .rd(rd), .rdIn(rdIn), .wr_count(wr_count)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bdata;
    logic        hld;
    logic        exp_ar;
    logic        exp_br;
    logic        exp_wr;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; hold = 0;
    a_rd = 0; b_rd = 0; a_data = 0; b_data = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic exp_a;
    rst = 1; idle_inputs();

    // vectors run back-to-back starting from reset state
    vecs[0] = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,    0, 1, 0, 1, 5'd5, 32'hDEADBEEF, 16'd1};
    vecs[1] = '{0, 5'd0, 32'h0,        1, 5'd0, 32'h1234, 0, 0, 1, 0, 5'd5, 32'hDEADBEEF, 16'd1};
    vecs[2] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    0, 0, 0, 0, 5'd5, 32'hDEADBEEF, 16'd1};
    vecs[3] = '{1, 5'd7, 32'h77,       0, 5'd0, 32'h0,    1, 0, 0, 0, 5'd5, 32'hDEADBEEF, 16'd1};
    vecs[4] = '{0, 5'd0, 32'h0,        1, 5'd3, 32'hB3,   0, 0, 1, 1, 5'd3, 32'hB3,       16'd2};
    vecs[5] = '{1, 5'd8, 32'h88,       1, 5'd9, 32'h99,   1, 0, 0, 0, 5'd3, 32'hB3,       16'd2};

    // reset state, readies blocked while rst is high
    @(negedge clk);
    a_valid = 1; a_rd = 5'd6; b_valid = 1; b_rd = 5'd6;
    #2;
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);
    step();
    check("rst_wr", wrReg, 0);
    check("rst_rd", rd, 0);
    check("rst_data", rdIn, 0);
    check("rst_cnt", wr_count, 0);
    idle_inputs();
    rst = 0;

    for (int i = 0; i < 6; i++) begin
      a_valid = vecs[i].av; a_rd = vecs[i].ard; a_data = vecs[i].adata;
      b_valid = vecs[i].bv; b_rd = vecs[i].brd; b_data = vecs[i].bdata;
      hold = vecs[i].hld;
      #2;
      check($sformatf("v%0d_a_ready", i), a_ready, vecs[i].exp_ar);
      check($sformatf("v%0d_b_ready", i), b_ready, vecs[i].exp_br);
      step();
      check($sformatf("v%0d_wr", i), wrReg, vecs[i].exp_wr);
      check($sformatf("v%0d_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_data", i), rdIn, vecs[i].exp_data);
      check($sformatf("v%0d_cnt", i), wr_count, vecs[i].exp_cnt);
    end
    idle_inputs();

    // write in flight completes even though hold rises behind it
    a_valid = 1; a_rd = 5'd10; a_data = 32'hA0;
    step();
    a_valid = 0; hold = 1;
    #2;
    check("hold_inflight_ready", a_ready, 0);
    check("hold_inflight_wr", wrReg, 1);
    check("hold_inflight_rd", rd, 5'd10);
    step();
    check("hold_inflight_after", wrReg, 0);
    idle_inputs();

    // hold for three cycles, then release
    a_valid = 1; a_rd = 5'd9; a_data = 32'h9999; hold = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check($sformatf("hold%0d_a_ready", i), a_ready, 0);
      step();
      check($sformatf("hold%0d_wr", i), wrReg, 0);
    end
    hold = 0;
    #2;
    check("hold_drop_a_ready", a_ready, 1);
    step();
    check("hold_drop_wr", wrReg, 1);
    check("hold_drop_rd", rd, 5'd9);
    check("hold_drop_data", rdIn, 32'h9999);
    idle_inputs();

    // reset in the same cycle as an eligible B request
    b_valid = 1; b_rd = 5'd4; b_data = 32'h44; rst = 1;
    #2;
    check("rstb_b_ready", b_ready, 0);
    step();
    check("rstb_wr", wrReg, 0);
    check("rstb_cnt", wr_count, 0);
    rst = 0;

    // persistent tie; first tie after reset must go to A
    a_valid = 1; a_rd = 5'd1; a_data = 32'h11;
    b_valid = 1; b_rd = 5'd2; b_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
`ifdef REGWB_RR_EN
      exp_a = (i % 2 == 0);
`else
      exp_a = 1'b1;
`endif
      #2;
      check($sformatf("tie%0d_a_ready", i), a_ready, exp_a);
      check($sformatf("tie%0d_b_ready", i), b_ready, !exp_a);
      step();
      check($sformatf("tie%0d_wr", i), wrReg, 1);
      check($sformatf("tie%0d_rd", i), rd, exp_a ? 5'd1 : 5'd2);
      check($sformatf("tie%0d_cnt", i), wr_count, i + 1);
    end
    idle_inputs();

    // saturation of the write counter
    do_reset();
    a_valid = 1; a_rd = 5'd1; a_data = 32'h5A;
    for (int i = 0; i < 65534; i++) step();
    check("sat_fffe", wr_count, 16'hFFFE);
    step();
    check("sat_ffff", wr_count, 16'hFFFF);
    step();
    check("sat_hold1", wr_count, 16'hFFFF);
    check("sat_wr", wrReg, 1);
    step();
    check("sat_hold2", wr_count, 16'hFFFF);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
